// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared state encoding and one-hot helper for the decoder blocks
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        BLANK  = 2'd2,
        SCAN   = 2'd3
    } dec_state_t;

    // Widest one-hot vector the helper can produce; callers truncate to their width.
    localparam int ONEHOT_MAX_W = 256;

    // Returns 1<<idx, or zero when idx falls outside the requested width.
    function automatic logic [ONEHOT_MAX_W-1:0] onehot(input int unsigned idx,
                                                        input int unsigned width);
        logic [ONEHOT_MAX_W-1:0] v;
        v = '0;
        if (idx < width) begin
            v = {{(ONEHOT_MAX_W-1){1'b0}}, 1'b1} << idx;
        end
        return v;
    endfunction

endpackage

// File: rtl/scan_step_counter.sv
// rtl/scan_step_counter.sv - dwell counter with modulo-2^SEL_W index and wrap pulse
module scan_step_counter #(
    parameter int SEL_W = 3,
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             run,
    output logic [SEL_W-1:0] idx_nxt,
    output logic             wrap
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic [SEL_W-1:0] r_idx;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_wrap_nxt;

    // Next index is exported so the owner can register the decoded strobe in the same edge
    always_comb begin
        w_cnt_nxt  = r_cnt;
        idx_nxt    = r_idx;
        w_wrap_nxt = 1'b0;
        if (clr) begin
            w_cnt_nxt = '0;
            idx_nxt   = '0;
        end else if (run) begin
            if (r_cnt == CNT_W'(DWELL - 1)) begin
                w_cnt_nxt  = '0;
                idx_nxt    = r_idx + SEL_W'(1);
                w_wrap_nxt = (r_idx == {SEL_W{1'b1}});
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
    end

    // Counter state and the registered wrap pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
            wrap  <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_idx <= idx_nxt;
            wrap  <= w_wrap_nxt;
        end
    end

endmodule

// File: rtl/decoder_nto2n_seq.sv
// rtl/decoder_nto2n_seq.sv - registered N-to-2^N one-hot decoder with direct and scan modes
module decoder_nto2n_seq
    import decoder_pkg::*;
#(
    parameter int SEL_W      = 3,
    parameter int OUT_W      = 1 << SEL_W,
    parameter int DWELL      = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] y,
    output logic             y_valid,
    output logic [SEL_W-1:0] scan_idx,
    output logic             wrap
);

    if ((OUT_W != (1 << SEL_W)) || (DWELL < 1) || (OUT_W > ONEHOT_MAX_W)) begin : g_bad_params
        $error("decoder_nto2n_seq: OUT_W must equal 2**SEL_W and DWELL must be >= 1");
    end

    // XOR mask applied to every decoded value; also the idle pattern
    localparam logic [OUT_W-1:0] Y_IDLE = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

    dec_state_t       r_state;
    logic [SEL_W-1:0] w_idx_nxt;
    logic             w_clr;
    logic             w_run;
    logic [OUT_W-1:0] w_y_sel;
    logic [OUT_W-1:0] w_y_scan;

    // Counter idles at zero outside SCAN so entry always starts from index 0;
    // leaving SCAN via mode=0 freezes it (clr low, run low) for one cycle only.
    assign w_clr    = !en || (r_state != SCAN);
    assign w_run    = en && (r_state == SCAN) && mode;
    assign in_ready = (r_state == DIRECT) && en && !mode;
    assign w_y_sel  = OUT_W'(onehot(32'(sel), OUT_W)) ^ Y_IDLE;
    assign w_y_scan = OUT_W'(onehot(32'(w_idx_nxt), OUT_W)) ^ Y_IDLE;

    scan_step_counter #(
        .SEL_W (SEL_W),
        .DWELL (DWELL)
    ) u_step (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (w_clr),
        .run     (w_run),
        .idx_nxt (w_idx_nxt),
        .wrap    (wrap)
    );

    // Mode FSM with registered strobe, valid flag and index; en=0 overrides everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            y        <= Y_IDLE;
            y_valid  <= 1'b0;
            scan_idx <= '0;
        end else if (!en) begin
            r_state  <= IDLE;
            y        <= Y_IDLE;
            y_valid  <= 1'b0;
            scan_idx <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= BLANK;
                    y       <= Y_IDLE;
                    y_valid <= 1'b0;
                end
                BLANK: begin
                    if (mode) begin
                        r_state  <= SCAN;
                        y        <= w_y_scan;
                        y_valid  <= 1'b1;
                        scan_idx <= w_idx_nxt;
                    end else begin
                        r_state <= DIRECT;
                        y       <= Y_IDLE;
                        y_valid <= 1'b0;
                    end
                end
                DIRECT: begin
                    if (mode) begin
                        r_state <= BLANK;
                        y       <= Y_IDLE;
                        y_valid <= 1'b0;
                    end else if (in_valid) begin
                        y        <= w_y_sel;
                        y_valid  <= 1'b1;
                        scan_idx <= sel;
                    end
                end
                SCAN: begin
                    if (!mode) begin
                        r_state <= BLANK;
                        y       <= Y_IDLE;
                        y_valid <= 1'b0;
                    end else begin
                        y        <= w_y_scan;
                        y_valid  <= 1'b1;
                        scan_idx <= w_idx_nxt;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    y       <= Y_IDLE;
                    y_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
